// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM state and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-request picker holding the round-robin 'last' register.
// Defining MEM_ARB_DCACHE_PRIORITY_EN makes the D-cache win every tie.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   ic_val,
    input  logic   dc_val,
    input  logic   done,
    input  owner_t served,
    output owner_t grant
);

    owner_t last_reg;

    // After reset 'last' points at D so the I-cache wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= OWN_D;
        end else if (done) begin
            last_reg <= served;
        end
    end

    always_comb begin
        grant = OWN_I;
        if (ic_val && dc_val) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
            grant = OWN_D;
`else
            grant = (last_reg == OWN_D) ? OWN_I : OWN_D;
`endif
        end else if (dc_val) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between I-cache and D-cache, one locked transaction
// at a time. Build option: MEM_ARB_DCACHE_PRIORITY_EN (fixed D-cache priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS       = 28,
    parameter int MEM_DATA_BITS   = 128,
    parameter int MEM_DATA_CYCLES = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ic_req_val,
    output logic                       ic_req_rdy,
    input  logic [ADDR_BITS-1:0]       ic_req_addr,
    output logic                       ic_resp_val,
    output logic                       ic_resp_nack,
    output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
    input  logic                       dc_req_val,
    input  logic                       dc_req_rw,
    output logic                       dc_req_rdy,
    input  logic [ADDR_BITS-1:0]       dc_req_addr,
    input  logic                       dc_req_data_valid,
    output logic                       dc_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    input  logic [1:0]                 dc_req_data_offset,
    output logic                       dc_resp_val,
    output logic                       dc_resp_nack,
    output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic                       mem_req_rw,
    output logic [ADDR_BITS-1:0]       mem_req_addr,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic [1:0]                 mem_req_data_offset,
    input  logic                       mem_resp_val,
    input  logic                       mem_resp_nack,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_BITS = $clog2(MEM_DATA_CYCLES);

    arb_state_t           state_reg;
    owner_t               owner_reg;
    logic [CNT_BITS-1:0]  cnt_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic                 rw_reg;

    owner_t               grant;
    logic                 any_req;
    logic                 last_beat;
    logic                 done;
    logic [ADDR_BITS-1:0] sel_addr;
    logic                 sel_rw;

    assign any_req   = ic_req_val | dc_req_val;
    assign sel_addr  = (grant == OWN_D) ? dc_req_addr : ic_req_addr;
    assign sel_rw    = (grant == OWN_D) && dc_req_rw;
    assign last_beat = (cnt_reg == {CNT_BITS{1'b1}});
    assign done      = ((state_reg == ST_WDATA) && mem_req_data_ready) ||
                       ((state_reg == ST_RESP) && mem_resp_val && !mem_resp_nack && last_beat);

    arb_rr2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .ic_val (ic_req_val),
        .dc_val (dc_req_val),
        .done   (done),
        .served (owner_reg),
        .grant  (grant)
    );

    // The request is captured at grant so a stalled REQ keeps forwarding it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_I;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rw_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg <= grant;
                        addr_reg  <= sel_addr;
                        rw_reg    <= sel_rw;
                        if (mem_req_rdy) begin
                            state_reg <= sel_rw ? ST_WDATA : ST_RESP;
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_rdy) begin
                        state_reg <= rw_reg ? ST_WDATA : ST_RESP;
                    end
                end
                ST_WDATA: begin
                    if (mem_req_data_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    // A nack restarts the refill from beat 0 with the same owner.
                    if (mem_resp_nack) begin
                        state_reg <= ST_REQ;
                        cnt_reg   <= '0;
                    end else if (mem_resp_val) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_val         = 1'b0;
        mem_req_rw          = 1'b0;
        mem_req_addr        = '0;
        mem_req_data_valid  = 1'b0;
        mem_req_data_bits   = '0;
        mem_req_data_mask   = '0;
        mem_req_data_offset = '0;
        ic_req_rdy          = 1'b0;
        dc_req_rdy          = 1'b0;
        dc_req_data_ready   = 1'b0;
        ic_resp_val         = 1'b0;
        ic_resp_nack        = 1'b0;
        dc_resp_val         = 1'b0;
        dc_resp_nack        = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        mem_req_val  = 1'b1;
                        mem_req_rw   = sel_rw;
                        mem_req_addr = sel_addr;
                        ic_req_rdy   = mem_req_rdy && (grant == OWN_I);
                        dc_req_rdy   = mem_req_rdy && (grant == OWN_D);
                    end
                end
                ST_REQ: begin
                    mem_req_val  = 1'b1;
                    mem_req_rw   = rw_reg;
                    mem_req_addr = addr_reg;
                    ic_req_rdy   = mem_req_rdy && (owner_reg == OWN_I);
                    dc_req_rdy   = mem_req_rdy && (owner_reg == OWN_D);
                end
                ST_WDATA: begin
                    mem_req_data_valid  = dc_req_data_valid;
                    mem_req_data_bits   = dc_req_data_bits;
                    mem_req_data_mask   = dc_req_data_mask;
                    mem_req_data_offset = dc_req_data_offset;
                    dc_req_data_ready   = mem_req_data_ready;
                end
                ST_RESP: begin
                    ic_resp_val  = mem_resp_val  && (owner_reg == OWN_I);
                    dc_resp_val  = mem_resp_val  && (owner_reg == OWN_D);
                    ic_resp_nack = mem_resp_nack && (owner_reg == OWN_I);
                    dc_resp_nack = mem_resp_nack && (owner_reg == OWN_D);
                end
                default: ;
            endcase
        end
    end

    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter: the bench plays both caches and
// the memory, predicting grant order from the fairness rule and checking every cycle.
module tb_mem_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_val, ic_req_rdy, ic_resp_val, ic_resp_nack;
    logic [27:0]   ic_req_addr;
    logic [127:0]  ic_resp_data;
    logic          dc_req_val, dc_req_rw, dc_req_rdy, dc_req_data_valid, dc_req_data_ready;
    logic [27:0]   dc_req_addr;
    logic [127:0]  dc_req_data_bits;
    logic [15:0]   dc_req_data_mask;
    logic [1:0]    dc_req_data_offset;
    logic          dc_resp_val, dc_resp_nack;
    logic [127:0]  dc_resp_data;
    logic          mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [27:0]   mem_req_addr;
    logic [127:0]  mem_req_data_bits;
    logic [15:0]   mem_req_data_mask;
    logic [1:0]    mem_req_data_offset;
    logic          mem_resp_val, mem_resp_nack;
    logic [127:0]  mem_resp_data;

    int   checks   = 0;
    int   failures = 0;
    logic prev_served;   // client served most recently (0=I, 1=D)

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
        .ic_resp_val(ic_resp_val), .ic_resp_nack(ic_resp_nack), .ic_resp_data(ic_resp_data),
        .dc_req_val(dc_req_val), .dc_req_rw(dc_req_rw), .dc_req_rdy(dc_req_rdy),
        .dc_req_addr(dc_req_addr), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask), .dc_req_data_offset(dc_req_data_offset),
        .dc_resp_val(dc_resp_val), .dc_resp_nack(dc_resp_nack), .dc_resp_data(dc_resp_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_req_data_offset(mem_req_data_offset),
        .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_data(mem_resp_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Winner of a request set, from the fairness rule: ties go to the client not served last.
    function automatic logic pick(input logic i_req, input logic d_req);
        if (i_req && d_req) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
            return 1'b1;
`else
            return !prev_served;
`endif
        end
        return d_req;
    endfunction

    task automatic check_quiet_resp(input string tag);
        check({tag, "_resp"}, {ic_resp_val, dc_resp_val, ic_resp_nack, dc_resp_nack}, 4'b0000);
    endtask

    // Memory withholds rdy for 'delay' cycles, then accepts; spurious beats must be dropped.
    task automatic req_phase(input logic w, input logic [27:0] a, input logic rw, input int delay);
        for (int c = 0; c <= delay; c++) begin
            mem_req_rdy   = (c == delay);
            mem_resp_val  = 1'($urandom_range(0, 1));
            mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("req_val", mem_req_val, 1'b1);
            check("req_addr", mem_req_addr, a);
            check("req_rw", mem_req_rw, rw);
            check("rdy_owner", w ? dc_req_rdy : ic_req_rdy, (c == delay));
            check("rdy_other", w ? ic_req_rdy : dc_req_rdy, 1'b0);
            check_quiet_resp("req");
            @(negedge clk);
        end
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        if (w) dc_req_val = 1'b0;
        else   ic_req_val = 1'b0;
    endtask

    task automatic wdata_phase(input logic [15:0] mask, input logic [1:0] off, input int delay);
        logic [127:0] bits;
        bits = {$urandom, $urandom, $urandom, $urandom};
        dc_req_data_valid  = 1'b1;
        dc_req_data_bits   = bits;
        dc_req_data_mask   = mask;
        dc_req_data_offset = off;
        for (int c = 0; c <= delay; c++) begin
            mem_req_data_ready = (c == delay);
            mem_resp_val       = 1'($urandom_range(0, 1));
            #1;
            check("wd_valid", mem_req_data_valid, 1'b1);
            check("wd_bits", mem_req_data_bits, bits);
            check("wd_mask", mem_req_data_mask, mask);
            check("wd_offset", mem_req_data_offset, off);
            check("wd_ready", dc_req_data_ready, (c == delay));
            check("wd_req_val", mem_req_val, 1'b0);
            check_quiet_resp("wd");
            @(negedge clk);
        end
        mem_req_data_ready = 1'b0;
        mem_resp_val       = 1'b0;
        dc_req_data_valid  = 1'b0;
    endtask

    // Delivers MEM_DATA_CYCLES beats with random gaps; an optional nack restarts the refill.
    task automatic resp_phase(input logic w, input logic [27:0] a, input int nack_at);
        int   b;
        logic nacked;
        logic gap, nk;
        logic [127:0] d;
        b = 0;
        nacked = 1'b0;
        while (b < 4) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            gap = ($urandom_range(0, 3) == 0);
            nk  = !nacked && !gap && (b == nack_at);
            mem_resp_val  = !gap && !nk;
            mem_resp_nack = nk;
            mem_resp_data = d;
            #1;
            check("resp_val_owner", w ? dc_resp_val : ic_resp_val, !gap && !nk);
            check("resp_val_other", w ? ic_resp_val : dc_resp_val, 1'b0);
            check("nack_owner", w ? dc_resp_nack : ic_resp_nack, nk);
            check("nack_other", w ? ic_resp_nack : dc_resp_nack, 1'b0);
            check("resp_req_val", mem_req_val, 1'b0);
            if (!gap) check("resp_data", w ? dc_resp_data : ic_resp_data, d);
            @(negedge clk);
            mem_resp_val  = 1'b0;
            mem_resp_nack = 1'b0;
            if (nk) begin
                nacked = 1'b1;
                b = 0;
                if (w) dc_req_val = 1'b1;
                else   ic_req_val = 1'b1;
                req_phase(w, a, 1'b0, $urandom_range(0, 2));
            end else if (!gap) begin
                b++;
            end
        end
    endtask

    // With nothing pending the block must be idle: no request, extra beats dropped.
    task automatic idle_check();
        mem_resp_val = 1'b1;
        #1;
        check("idle_req_val", mem_req_val, 1'b0);
        check_quiet_resp("idle");
        @(negedge clk);
        mem_resp_val = 1'b0;
    endtask

    initial begin
        logic        pend_i, pend_d, w, rw;
        logic [27:0] a;
        logic [15:0] mask;
        logic [1:0]  off;
        int          wdelay;

        reset = 1'b1;
        ic_req_val = 1'b1; ic_req_addr = 28'h100;
        dc_req_val = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0;
        dc_req_data_valid = 1'b0; dc_req_data_bits = '0; dc_req_data_mask = '0; dc_req_data_offset = '0;
        mem_req_rdy = 1'b1; mem_req_data_ready = 1'b0;
        mem_resp_val = 1'b0; mem_resp_nack = 1'b0; mem_resp_data = '0;
        prev_served = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_val", mem_req_val, 1'b0);
        check("rst_rdy", {ic_req_rdy, dc_req_rdy, dc_req_data_ready}, 3'b000);
        check_quiet_resp("rst");
        @(negedge clk);
        reset = 1'b0;
        ic_req_val = 1'b0;
        mem_req_rdy = 1'b0;
        #1;
        check("post_rst_req_val", mem_req_val, 1'b0);
        check("post_rst_data_valid", mem_req_data_valid, 1'b0);
        @(negedge clk);

        for (int s = 0; s < 40; s++) begin
            pend_i = (s < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            pend_d = (s < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (s == 2) pend_i = 1'b0;
            if (!pend_i && !pend_d) pend_i = 1'b1;
            ic_req_val  = pend_i;
            ic_req_addr = (s == 0) ? 28'h100 : 28'($urandom);
            dc_req_val  = pend_d;
            dc_req_addr = 28'($urandom);
            dc_req_rw   = (s == 2) ? 1'b1 : (s < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            while (pend_i || pend_d) begin
                w  = pick(pend_i, pend_d);
                a  = w ? dc_req_addr : ic_req_addr;
                rw = w && dc_req_rw;
                req_phase(w, a, rw, (s == 0) ? 0 : $urandom_range(0, 3));
                if (rw) begin
                    mask   = (s == 2) ? 16'h000F : 16'($urandom);
                    off    = (s == 2) ? 2'd2 : 2'($urandom);
                    wdelay = (s == 2) ? 3 : $urandom_range(0, 3);
                    wdata_phase(mask, off, wdelay);
                end else begin
                    resp_phase(w, a, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1);
                end
                prev_served = w;
                if (w) pend_d = 1'b0;
                else   pend_i = 1'b0;
            end
            $display("scenario %0d done: last=%0d checks=%0d", s, prev_served, checks);
            idle_check();
        end

        // Reset in the middle of a D refill, then a fresh refill must take all four beats.
        dc_req_val = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0ABCDE;
        req_phase(1'b1, 28'h0ABCDE, 1'b0, 0);
        for (int b = 0; b < 2; b++) begin
            mem_resp_val = 1'b1;
            #1;
            check("pre_rst_beat", dc_resp_val, 1'b1);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_resp", dc_resp_val, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        prev_served = 1'b1;
        #1;
        check("after_rst_resp", dc_resp_val, 1'b0);
        check("after_rst_req_val", mem_req_val, 1'b0);
        @(negedge clk);
        mem_resp_val = 1'b0;
        dc_req_val = 1'b1; dc_req_addr = 28'h0123456;
        req_phase(1'b1, 28'h0123456, 1'b0, 1);
        resp_phase(1'b1, 28'h0123456, -1);
        $display("reset mid-refill sequence done: checks=%0d", checks);
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
